// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and scan-code classifiers for the PS/2 scan-code-set-2 decoder.
package ps2_pkg;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] ASC_UP    = 8'h80;
  localparam logic [7:0] ASC_DOWN  = 8'h81;
  localparam logic [7:0] ASC_LEFT  = 8'h82;
  localparam logic [7:0] ASC_RIGHT = 8'h83;
  localparam logic [7:0] ASC_HOME  = 8'h84;
  localparam logic [7:0] ASC_END   = 8'h85;
  localparam logic [7:0] ASC_DEL   = 8'h7F;
  localparam logic [7:0] ASC_CR    = 8'h0D;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} ps2_state_e;

  // Keyboard responses (BAT ok, ACK, errors, echo, overrun) that carry no key information.
  function automatic logic is_ignored(input logic [7:0] code);
    case (code)
      8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_ignored = 1'b1;
      default: is_ignored = 1'b0;
    endcase
  endfunction

  function automatic logic is_letter_code(input logic [7:0] code);
    case (code)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: is_letter_code = 1'b1;
      default: is_letter_code = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code-set-2 to ASCII ROM; shift_sel picks the shifted column, 0x00 means unmapped.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       shift_sel,
  output logic [7:0] ascii
);

  logic [15:0] pair_s;

  // Each entry is {unshifted, shifted}.
  always_comb begin
    pair_s = 16'h0000;
    case (scan_code)
      8'h1C: pair_s = {8'h61, 8'h41};  8'h32: pair_s = {8'h62, 8'h42};
      8'h21: pair_s = {8'h63, 8'h43};  8'h23: pair_s = {8'h64, 8'h44};
      8'h24: pair_s = {8'h65, 8'h45};  8'h2B: pair_s = {8'h66, 8'h46};
      8'h34: pair_s = {8'h67, 8'h47};  8'h33: pair_s = {8'h68, 8'h48};
      8'h43: pair_s = {8'h69, 8'h49};  8'h3B: pair_s = {8'h6A, 8'h4A};
      8'h42: pair_s = {8'h6B, 8'h4B};  8'h4B: pair_s = {8'h6C, 8'h4C};
      8'h3A: pair_s = {8'h6D, 8'h4D};  8'h31: pair_s = {8'h6E, 8'h4E};
      8'h44: pair_s = {8'h6F, 8'h4F};  8'h4D: pair_s = {8'h70, 8'h50};
      8'h15: pair_s = {8'h71, 8'h51};  8'h2D: pair_s = {8'h72, 8'h52};
      8'h1B: pair_s = {8'h73, 8'h53};  8'h2C: pair_s = {8'h74, 8'h54};
      8'h3C: pair_s = {8'h75, 8'h55};  8'h2A: pair_s = {8'h76, 8'h56};
      8'h1D: pair_s = {8'h77, 8'h57};  8'h22: pair_s = {8'h78, 8'h58};
      8'h35: pair_s = {8'h79, 8'h59};  8'h1A: pair_s = {8'h7A, 8'h5A};
      8'h16: pair_s = {8'h31, 8'h21};  8'h1E: pair_s = {8'h32, 8'h40};
      8'h26: pair_s = {8'h33, 8'h23};  8'h25: pair_s = {8'h34, 8'h24};
      8'h2E: pair_s = {8'h35, 8'h25};  8'h36: pair_s = {8'h36, 8'h5E};
      8'h3D: pair_s = {8'h37, 8'h26};  8'h3E: pair_s = {8'h38, 8'h2A};
      8'h46: pair_s = {8'h39, 8'h28};  8'h45: pair_s = {8'h30, 8'h29};
      8'h0E: pair_s = {8'h60, 8'h7E};  8'h4E: pair_s = {8'h2D, 8'h5F};
      8'h55: pair_s = {8'h3D, 8'h2B};  8'h5D: pair_s = {8'h5C, 8'h7C};
      8'h54: pair_s = {8'h5B, 8'h7B};  8'h5B: pair_s = {8'h5D, 8'h7D};
      8'h4C: pair_s = {8'h3B, 8'h3A};  8'h52: pair_s = {8'h27, 8'h22};
      8'h41: pair_s = {8'h2C, 8'h3C};  8'h49: pair_s = {8'h2E, 8'h3E};
      8'h4A: pair_s = {8'h2F, 8'h3F};  8'h29: pair_s = {8'h20, 8'h20};
      8'h5A: pair_s = {8'h0D, 8'h0D};  8'h66: pair_s = {8'h08, 8'h08};
      8'h0D: pair_s = {8'h09, 8'h09};  8'h76: pair_s = {8'h1B, 8'h1B};
      default: pair_s = 16'h0000;
    endcase
    ascii = shift_sel ? pair_s[7:0] : pair_s[15:8];
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, modifier tracking and a one-deep ASCII output register.
// Define PS2_EXTENDED_KEYS_EN to map E0-prefixed cursor/navigation keys to 0x7F/0x80-0x85/0x0D.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int E1_SKIP_BYTES = 7,
  parameter bit CAPS_INIT     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       drop,
  output logic [3:0] mod_state
);

  localparam int CW = (E1_SKIP_BYTES > 1) ? $clog2(E1_SKIP_BYTES + 1) : 1;

  ps2_state_e    state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic          shift_l_r, shift_l_n, shift_r_r, shift_r_n;
  logic          ctrl_r, ctrl_n, caps_r, caps_n, caps_held_r, caps_held_n;
  logic          char_valid_s;
  logic [7:0]    char_data_s;
  logic          letter_s, shift_s, shift_sel_s;
  logic [7:0]    map_ascii_s;

  assign letter_s    = is_letter_code(scan_code);
  assign shift_s     = shift_l_r | shift_r_r;
  assign shift_sel_s = letter_s ? (shift_s ^ caps_r) : shift_s;
  assign mod_state   = {caps_r, ctrl_r, shift_r_r, shift_l_r};

  ps2_keymap u_keymap (
    .scan_code (scan_code),
    .shift_sel (shift_sel_s),
    .ascii     (map_ascii_s)
  );

  // Prefix state machine, modifier updates and character generation; advances only on a strobe.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    shift_l_n    = shift_l_r;
    shift_r_n    = shift_r_r;
    ctrl_n       = ctrl_r;
    caps_n       = caps_r;
    caps_held_n  = caps_held_r;
    char_valid_s = 1'b0;
    char_data_s  = 8'h00;
    if (scan_valid) begin
      case (state_r)
        IDLE: begin
          if (scan_code == PFX_E0) begin
            state_n = EXT;
          end else if (scan_code == PFX_F0) begin
            state_n = BRK;
          end else if (scan_code == PFX_E1) begin
            state_n = SKIP;
            cnt_n   = CW'(E1_SKIP_BYTES);
          end else if (is_ignored(scan_code)) begin
            state_n = IDLE;
          end else begin
            case (scan_code)
              SC_LSHIFT: shift_l_n = 1'b1;
              SC_RSHIFT: shift_r_n = 1'b1;
              SC_CTRL:   ctrl_n    = 1'b1;
              SC_CAPS: begin
                // Typematic repeats arrive while held; only the first make toggles.
                caps_n      = caps_held_r ? caps_r : ~caps_r;
                caps_held_n = 1'b1;
              end
              default: begin
                char_valid_s = (map_ascii_s != 8'h00);
                char_data_s  = (ctrl_r && letter_s) ? (map_ascii_s & 8'h1F) : map_ascii_s;
              end
            endcase
          end
        end
        EXT: begin
          state_n = IDLE;
          case (scan_code)
            PFX_F0:               state_n = EXTBRK;
            SC_CTRL:              ctrl_n  = 1'b1;
            SC_LSHIFT, SC_RSHIFT: state_n = IDLE;
            default: begin
`ifdef PS2_EXTENDED_KEYS_EN
              char_valid_s = 1'b1;
              case (scan_code)
                8'h75:   char_data_s = ASC_UP;
                8'h72:   char_data_s = ASC_DOWN;
                8'h6B:   char_data_s = ASC_LEFT;
                8'h74:   char_data_s = ASC_RIGHT;
                8'h6C:   char_data_s = ASC_HOME;
                8'h69:   char_data_s = ASC_END;
                8'h71:   char_data_s = ASC_DEL;
                8'h5A:   char_data_s = ASC_CR;
                default: char_valid_s = 1'b0;
              endcase
`else
              char_valid_s = 1'b0;
`endif
            end
          endcase
        end
        BRK: begin
          state_n = IDLE;
          case (scan_code)
            SC_LSHIFT: shift_l_n   = 1'b0;
            SC_RSHIFT: shift_r_n   = 1'b0;
            SC_CTRL:   ctrl_n      = 1'b0;
            SC_CAPS:   caps_held_n = 1'b0;
            default:   state_n     = IDLE;
          endcase
        end
        EXTBRK: begin
          state_n = IDLE;
          ctrl_n  = (scan_code == SC_CTRL) ? 1'b0 : ctrl_r;
        end
        SKIP: begin
          if (cnt_r <= CW'(1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r - CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Decoder state and modifier registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      shift_l_r   <= 1'b0;
      shift_r_r   <= 1'b0;
      ctrl_r      <= 1'b0;
      caps_r      <= CAPS_INIT;
      caps_held_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      shift_l_r   <= shift_l_n;
      shift_r_r   <= shift_r_n;
      ctrl_r      <= ctrl_n;
      caps_r      <= caps_n;
      caps_held_r <= caps_held_n;
    end
  end

  // One-deep output register: a held character wins over a new one, which is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      drop      <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (char_valid_s) begin
        if (out_valid && !out_ready) begin
          drop <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_data  <= char_data_s;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed self-checking bench for ps2_scan_decoder; inputs change 1 ns after posedge, checks run on negedge.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       drop;
  logic [3:0] mod_state;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         acc_cnt = 0;
  int         drop_cnt = 0;
  logic [7:0] last_acc = 8'h00;

  ps2_scan_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop      (drop),
    .mod_state (mod_state)
  );

  always #5 clk = ~clk;

  // Handshake monitor: a beat with valid & ready at negedge is taken on the following posedge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= out_data;
    end
    if (drop) drop_cnt <= drop_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] c);
    @(posedge clk); #1;
    scan_valid = 1'b1;
    scan_code  = c;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vec_cnt++; if (out_data !== 8'h00) begin err_cnt++; $display("FAIL reset_data got %h want 00", out_data); end
    vec_cnt++; if (drop !== 1'b0) begin err_cnt++; $display("FAIL reset_drop got %b want 0", drop); end
    vec_cnt++; if (mod_state !== 4'b0000) begin err_cnt++; $display("FAIL reset_mod got %b want 0000", mod_state); end
  endtask

  task automatic test_make_break();
    int a0;
    a0 = acc_cnt;
    send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin err_cnt++; $display("FAIL make_a got v=%b d=%h want v=1 d=61", out_valid, out_data); end
    idle(2);
    vec_cnt++; if (acc_cnt - a0 !== 1 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL make_a_beats got %0d v=%b want 1 v=0", acc_cnt - a0, out_valid); end
    a0 = acc_cnt;
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'hAA); send_byte(8'hFA);
    idle(3);
    vec_cnt++; if (acc_cnt - a0 !== 0) begin err_cnt++; $display("FAIL break_silent got %0d beats want 0", acc_cnt - a0); end
  endtask

  task automatic test_shift();
    send_byte(8'h12);
    @(negedge clk);
    vec_cnt++; if (mod_state !== 4'b0001) begin err_cnt++; $display("FAIL shift_l_set got %b want 0001", mod_state); end
    send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h41) begin err_cnt++; $display("FAIL shift_A got %h want 41", out_data); end
    send_byte(8'hF0); send_byte(8'h12);
    @(negedge clk);
    vec_cnt++; if (mod_state !== 4'b0000) begin err_cnt++; $display("FAIL shift_l_clr got %b want 0000", mod_state); end
    send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h61) begin err_cnt++; $display("FAIL unshift_a got %h want 61", out_data); end
    idle(2);
  endtask

  task automatic test_caps();
    send_byte(8'h58); send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    @(negedge clk);
    vec_cnt++; if (mod_state !== 4'b1000) begin err_cnt++; $display("FAIL caps_once got %b want 1000", mod_state); end
    send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h41) begin err_cnt++; $display("FAIL caps_A got %h want 41", out_data); end
    send_byte(8'h16);
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h31) begin err_cnt++; $display("FAIL caps_digit got %h want 31", out_data); end
    send_byte(8'h12); send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h61) begin err_cnt++; $display("FAIL caps_shift_a got %h want 61", out_data); end
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    @(negedge clk);
    vec_cnt++; if (mod_state !== 4'b0000) begin err_cnt++; $display("FAIL caps_off got %b want 0000", mod_state); end
    idle(2);
  endtask

  task automatic test_ctrl();
    send_byte(8'h14); send_byte(8'h21);
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h03 || mod_state !== 4'b0100) begin err_cnt++; $display("FAIL ctrl_c got d=%h m=%b want 03 0100", out_data, mod_state); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    @(negedge clk);
    vec_cnt++; if (mod_state !== 4'b0000) begin err_cnt++; $display("FAIL ext_ctrl_clr got %b want 0000", mod_state); end
    send_byte(8'h21);
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h63) begin err_cnt++; $display("FAIL plain_c got %h want 63", out_data); end
    send_byte(8'hE0); send_byte(8'h14);
    @(negedge clk);
    vec_cnt++; if (mod_state !== 4'b0100) begin err_cnt++; $display("FAIL ext_ctrl_set got %b want 0100", mod_state); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    send_byte(8'hE0); send_byte(8'h12);
    @(negedge clk);
    vec_cnt++; if (mod_state !== 4'b0000) begin err_cnt++; $display("FAIL fake_shift got %b want 0000", mod_state); end
    idle(2);
  endtask

  task automatic test_pause_skip();
    int a0;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    a0 = acc_cnt;
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    idle(3);
    vec_cnt++; if (acc_cnt - a0 !== 0 || mod_state !== 4'b0000) begin err_cnt++; $display("FAIL pause_skip got beats=%0d m=%b want 0 0000", acc_cnt - a0, mod_state); end
    send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin err_cnt++; $display("FAIL after_pause got v=%b d=%h want 1 61", out_valid, out_data); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    send_byte(8'hF0);
    pulse_reset();
    send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin err_cnt++; $display("FAIL reset_mid got v=%b d=%h want 1 61", out_valid, out_data); end
    idle(2);
  endtask

  task automatic test_keymap();
    logic [7:0] codes [10];
    logic       shs   [10];
    logic [7:0] exps  [10];
    codes = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h16, 8'h45, 8'h4E, 8'h4A, 8'h52};
    shs   = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    exps  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B, 8'h21, 8'h30, 8'h5F, 8'h2F, 8'h22};
    for (int i = 0; i < 10; i++) begin
      if (shs[i]) send_byte(8'h59);
      send_byte(codes[i]);
      @(negedge clk);
      vec_cnt++; if (out_valid !== 1'b1 || out_data !== exps[i]) begin err_cnt++; $display("FAIL keymap_%h got v=%b d=%h want 1 %h", codes[i], out_valid, out_data, exps[i]); end
      if (shs[i]) begin send_byte(8'hF0); send_byte(8'h59); end
      idle(2);
    end
  endtask

  task automatic test_backpressure();
    int a0, d0;
    a0 = acc_cnt; d0 = drop_cnt;
    out_ready = 1'b0;
    send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin err_cnt++; $display("FAIL bp_first got v=%b d=%h want 1 61", out_valid, out_data); end
    send_byte(8'h32);
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h61 || drop !== 1'b1) begin err_cnt++; $display("FAIL bp_hold got d=%h drop=%b want 61 1", out_data, drop); end
    idle(3);
    vec_cnt++; if (drop_cnt - d0 !== 1 || out_data !== 8'h61 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_drop_once got drops=%0d d=%h want 1 61", drop_cnt - d0, out_data); end
    out_ready = 1'b1;
    idle(2);
    vec_cnt++; if (acc_cnt - a0 !== 1 || last_acc !== 8'h61 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_release got beats=%0d last=%h v=%b want 1 61 0", acc_cnt - a0, last_acc, out_valid); end
  endtask

  task automatic test_back_to_back();
    int a0, d0;
    a0 = acc_cnt; d0 = drop_cnt;
    @(posedge clk); #1;
    scan_valid = 1'b1; scan_code = 8'h1C;
    @(posedge clk); #1;
    scan_code = 8'h32;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h62) begin err_cnt++; $display("FAIL b2b_load got v=%b d=%h want 1 62", out_valid, out_data); end
    idle(2);
    vec_cnt++; if (acc_cnt - a0 !== 2 || last_acc !== 8'h62 || drop_cnt - d0 !== 0) begin err_cnt++; $display("FAIL b2b_beats got beats=%0d last=%h drops=%0d want 2 62 0", acc_cnt - a0, last_acc, drop_cnt - d0); end
  endtask

  task automatic test_extended();
    int a0;
    a0 = acc_cnt;
    send_byte(8'hE0); send_byte(8'h75);
    idle(3);
`ifdef PS2_EXTENDED_KEYS_EN
    vec_cnt++; if (acc_cnt - a0 !== 1 || last_acc !== 8'h80) begin err_cnt++; $display("FAIL ext_up got beats=%0d last=%h want 1 80", acc_cnt - a0, last_acc); end
`else
    vec_cnt++; if (acc_cnt - a0 !== 0) begin err_cnt++; $display("FAIL ext_up_off got beats=%0d want 0", acc_cnt - a0); end
`endif
    send_byte(8'h1C);
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin err_cnt++; $display("FAIL after_ext got v=%b d=%h want 1 61", out_valid, out_data); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_shift();
    test_caps();
    test_ctrl();
    test_pause_skip();
    test_reset_mid();
    test_keymap();
    test_backpressure();
    test_back_to_back();
    test_extended();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
